// File: rtl/param_systolic_mac_pcpi.sv
// PCPI co-processor: NxN signed matrix multiply-accumulate on an output-stationary systolic array.
// Latency: register/read ops answer 1 cycle after accept; START/START_ACC answer 3N cycles after accept.
// Backpressure: pcpi_wait holds the core while the array runs; a one-cycle guard after ready blocks re-accept.
module param_systolic_mac_pcpi #(
    parameter int N    = 3,
    parameter int DW   = 16,
    parameter int ACCW = 2*DW+4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        pcpi_valid,
    input  logic [31:0] pcpi_insn,
    input  logic [31:0] pcpi_rs1,
    input  logic [31:0] pcpi_rs2,
    output logic        pcpi_wr,
    output logic [31:0] pcpi_rd,
    output logic        pcpi_wait,
    output logic        pcpi_ready
);

    localparam int NN = N*N;
    localparam int PW = 2*DW;
    localparam int CW = $clog2(3*N);
    localparam int EW = (ACCW > 32) ? ACCW : 33;
    localparam logic [CW-1:0] CNT_LAST = CW'(3*N-2);
    localparam logic [6:0] OPC = 7'b0001011;
    localparam logic [2:0] F_WRITE = 3'b000;
    localparam logic [2:0] F_START = 3'b001;
    localparam logic [2:0] F_START_ACC = 3'b010;
    localparam logic [2:0] F_READ_C = 3'b100;
    localparam logic [2:0] F_READ_FLAGS = 3'b101;
    localparam logic [2:0] F_CLEAR = 3'b110;
    localparam logic signed [EW-1:0] SAT_MAX = EW'(64'sd2147483647);
    localparam logic signed [EW-1:0] SAT_MIN = EW'(-64'sd2147483648);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic signed [DW-1:0]   a_mem_q [NN];
    logic signed [DW-1:0]   a_mem_d [NN];
    logic signed [DW-1:0]   b_mem_q [NN];
    logic signed [DW-1:0]   b_mem_d [NN];
    logic signed [DW-1:0]   bias_q [NN];
    logic signed [DW-1:0]   bias_d [NN];
    logic signed [DW-1:0]   thr_q, thr_d;
    logic signed [ACCW-1:0] c_q [NN];
    logic signed [ACCW-1:0] c_d [NN];
    logic signed [ACCW-1:0] acc_q [NN];
    logic signed [ACCW-1:0] acc_d [NN];
    logic signed [DW-1:0]   ah_q [NN];
    logic signed [DW-1:0]   ah_d [NN];
    logic signed [DW-1:0]   bv_q [NN];
    logic signed [DW-1:0]   bv_d [NN];
    logic                   ready_q, ready_d;
    logic                   wr_q, wr_d;
    logic                   wait_q, wait_d;
    logic                   guard_q, guard_d;
    logic [31:0]            rd_q, rd_d;

    logic signed [DW-1:0]   a_inj [N];
    logic signed [DW-1:0]   b_inj [N];
    logic signed [DW-1:0]   a_left [NN];
    logic signed [DW-1:0]   b_up [NN];
    logic signed [PW-1:0]   prod [NN];
    logic signed [ACCW-1:0] acc_nxt [NN];
    logic [31:0]            live_mask, run_mask;
    logic [6:0]             opcode;
    logic [2:0]             funct3;
    logic [5:0]             idx;
    logic [1:0]             region;
    logic                   accept;
    logic                   unused_bits;

    function automatic logic [31:0] sat32(input logic signed [ACCW-1:0] v);
        logic signed [EW-1:0] ve;
        ve = EW'(v);
        if (ve > SAT_MAX) return 32'h7FFF_FFFF;
        else if (ve < SAT_MIN) return 32'h8000_0000;
        else return ve[31:0];
    endfunction

    function automatic logic ge_thr(input logic signed [ACCW-1:0] v, input logic signed [DW-1:0] t);
        return v >= ACCW'(t);
    endfunction

    assign opcode      = pcpi_insn[6:0];
    assign funct3      = pcpi_insn[14:12];
    assign idx         = pcpi_rs1[5:0];
    assign region      = pcpi_rs1[7:6];
    assign accept      = (state_q == S_IDLE) && pcpi_valid && (opcode == OPC) && !ready_q && !guard_q;
    assign unused_bits = ^{pcpi_insn, pcpi_rs1, pcpi_rs2};

    // Skewed edge injection: row r sees A[r][cnt-r], column c sees B[cnt-c][c], so PE(r,c) meets
    // matching A/B terms on the same cycle after they ripple right/down through the operand registers.
    always_comb begin
        for (int r = 0; r < N; r++) begin
            a_inj[r] = '0;
            b_inj[r] = '0;
            for (int j = 0; j < N; j++) begin
                if (cnt_q == CW'(r + j)) begin
                    a_inj[r] = a_mem_q[r*N + j];
                    b_inj[r] = b_mem_q[j*N + r];
                end
            end
        end
        for (int r = 0; r < N; r++) begin
            a_left[r*N] = a_inj[r];
            for (int c = 1; c < N; c++) a_left[r*N + c] = ah_q[r*N + c - 1];
        end
        for (int c = 0; c < N; c++) b_up[c] = b_inj[c];
        for (int k = N; k < NN; k++) b_up[k] = bv_q[k - N];
        live_mask = '0;
        run_mask  = '0;
        for (int k = 0; k < NN; k++) begin
            prod[k]      = PW'(a_left[k]) * PW'(b_up[k]);
            acc_nxt[k]   = acc_q[k] + ACCW'(prod[k]);
            live_mask[k] = ge_thr(c_q[k], thr_q);
            run_mask[k]  = ge_thr(acc_nxt[k], thr_q);
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        thr_d   = thr_q;
        a_mem_d = a_mem_q;
        b_mem_d = b_mem_q;
        bias_d  = bias_q;
        c_d     = c_q;
        acc_d   = acc_q;
        ah_d    = ah_q;
        bv_d    = bv_q;
        ready_d = 1'b0;
        wr_d    = 1'b0;
        rd_d    = '0;
        wait_d  = wait_q;
        guard_d = ready_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    case (funct3)
                        F_WRITE: begin
                            ready_d = 1'b1;
                            if (region == 2'd3) begin
                                thr_d = pcpi_rs2[DW-1:0];
                            end else begin
                                for (int k = 0; k < NN; k++) begin
                                    if (idx == 6'(k)) begin
                                        case (region)
                                            2'd0:    a_mem_d[k] = pcpi_rs2[DW-1:0];
                                            2'd1:    b_mem_d[k] = pcpi_rs2[DW-1:0];
                                            default: bias_d[k]  = pcpi_rs2[DW-1:0];
                                        endcase
                                    end
                                end
                            end
                        end
                        F_START, F_START_ACC: begin
                            state_d = S_RUN;
                            cnt_d   = '0;
                            wait_d  = 1'b1;
                            for (int k = 0; k < NN; k++) begin
                                ah_d[k]  = '0;
                                bv_d[k]  = '0;
                                acc_d[k] = (funct3 == F_START) ? ACCW'(bias_q[k]) : c_q[k];
                            end
                        end
                        F_READ_C: begin
                            ready_d = 1'b1;
                            wr_d    = 1'b1;
                            for (int k = 0; k < NN; k++) begin
                                if (idx == 6'(k)) rd_d = sat32(c_q[k]);
                            end
                        end
                        F_READ_FLAGS: begin
                            ready_d = 1'b1;
                            wr_d    = 1'b1;
                            rd_d    = live_mask;
                        end
                        F_CLEAR: begin
                            ready_d = 1'b1;
                            for (int k = 0; k < NN; k++) c_d[k] = '0;
                        end
                        default: ready_d = 1'b1;
                    endcase
                end
            end
            S_RUN: begin
                cnt_d = cnt_q + CW'(1);
                acc_d = acc_nxt;
                ah_d  = a_left;
                bv_d  = b_up;
                // Response is registered on the last MAC edge so ready lands exactly 3N after accept.
                if (cnt_q == CNT_LAST) begin
                    state_d = S_DONE;
                    wait_d  = 1'b0;
                    ready_d = 1'b1;
                    wr_d    = 1'b1;
                    rd_d    = run_mask;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                c_d     = acc_q;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            thr_q   <= '0;
            ready_q <= 1'b0;
            wr_q    <= 1'b0;
            wait_q  <= 1'b0;
            guard_q <= 1'b0;
            rd_q    <= '0;
            for (int k = 0; k < NN; k++) begin
                a_mem_q[k] <= '0;
                b_mem_q[k] <= '0;
                bias_q[k]  <= '0;
                c_q[k]     <= '0;
                acc_q[k]   <= '0;
                ah_q[k]    <= '0;
                bv_q[k]    <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            thr_q   <= thr_d;
            ready_q <= ready_d;
            wr_q    <= wr_d;
            wait_q  <= wait_d;
            guard_q <= guard_d;
            rd_q    <= rd_d;
            a_mem_q <= a_mem_d;
            b_mem_q <= b_mem_d;
            bias_q  <= bias_d;
            c_q     <= c_d;
            acc_q   <= acc_d;
            ah_q    <= ah_d;
            bv_q    <= bv_d;
        end
    end

    assign pcpi_wr    = wr_q;
    assign pcpi_rd    = rd_q;
    assign pcpi_wait  = wait_q;
    assign pcpi_ready = ready_q;

endmodule
